// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and the exception unit:
// sequencer state encoding, alignment mask and default vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_t;

  // Instruction words are 4-byte aligned; any set bit here is a misaligned target.
  localparam logic [1:0]  ALIGN_MASK           = 2'b11;

  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEFAULT_FAULT_VECTOR = 64'h100;

  // True when the low address bits of a redirect target break word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_low);
    return |(addr_low & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_boot_counter.sv
// Down-counter used to hold the sequencer in BOOT for a fixed number of
// cycles after reset. Loads on 'load', counts down on 'dec', parks at zero.
module pc_boot_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Load has priority; otherwise decrement until the counter reaches zero.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the LEGv8 fetch stage. Owns the fetch address,
// advances it under a valid/ready handshake, takes branch redirects (trapping
// misaligned targets to the fault vector), and supports a boot hold and halt.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          WIDTH        = 64,
  parameter logic [63:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [63:0] FAULT_VECTOR = DEFAULT_FAULT_VECTOR,
  parameter int          INC_BYTES    = 4,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             PC_READY,
  input  logic             STALL,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_TARGET,
  input  logic             HALT_REQ,
  input  logic             RESUME,
  output logic [WIDTH-1:0] PC,
  output logic             PC_VALID,
  output logic [WIDTH-1:0] PC_LINK,
  output logic             ALIGN_FAULT,
  output logic [WIDTH-1:0] FAULT_ADDR,
  output logic             HALTED
);

  localparam logic [WIDTH-1:0] INC_VALUE   = WIDTH'(INC_BYTES);
  localparam logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] FAULT_PC    = WIDTH'(FAULT_VECTOR);
  localparam int               CNT_W       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LOAD   = CNT_W'(BOOT_CYCLES - 1);

  pc_state_t        state;
  pc_state_t        next_state;
  logic [CNT_W-1:0] boot_count;
  logic             boot_zero;
  logic             accept;
  logic             branch_ok;
  logic             target_bad;
  logic [WIDTH-1:0] pc_next_seq;

  // Boot hold: reloaded by reset, runs down only while in BOOT.
  pc_boot_counter #(
    .CNT_W (CNT_W)
  ) u_boot_counter (
    .clk        (CLOCK),
    .load       (RESET),
    .load_value (BOOT_LOAD),
    .dec        (state == ST_BOOT),
    .count      (boot_count),
    .zero       (boot_zero)
  );

  // The increment wraps modulo 2^WIDTH by construction of the adder width.
  assign pc_next_seq = PC + INC_VALUE;
  assign PC_LINK     = pc_next_seq;

  // A fetch is consumed only when the request is live and the pipeline can take it.
  assign accept      = PC_VALID && PC_READY && !STALL;

  // Redirects are dropped during boot; in RUN and HALT they always win over accept.
  assign branch_ok   = BRANCH_TAKEN && (state != ST_BOOT);
  assign target_bad  = is_misaligned(BRANCH_TARGET[1:0]);

  // Next-state decode for the BOOT/RUN/HALT control.
  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT: if (boot_zero)             next_state = ST_RUN;
      ST_RUN:  if (HALT_REQ)              next_state = ST_HALT;
      ST_HALT: if (RESUME && !HALT_REQ)   next_state = ST_RUN;
      default:                            next_state = ST_BOOT;
    endcase
  end

  // State, PC and registered status outputs; reset overrides any pending redirect.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= ST_BOOT;
      PC          <= RESET_PC;
      PC_VALID    <= 1'b0;
      ALIGN_FAULT <= 1'b0;
      FAULT_ADDR  <= '0;
      HALTED      <= 1'b0;
    end else begin
      state       <= next_state;
      PC_VALID    <= (next_state == ST_RUN);
      HALTED      <= (next_state == ST_HALT);
      ALIGN_FAULT <= branch_ok && target_bad;
      if (branch_ok) begin
        if (target_bad) begin
          PC         <= FAULT_PC;
          FAULT_ADDR <= BRANCH_TARGET;
        end else begin
          PC <= BRANCH_TARGET;
        end
      end else if (accept) begin
        PC <= pc_next_seq;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Two instances share stimulus: a 64-bit
// default build and an 8-bit build used for the address wrap cases.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ready;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halt_req;
  logic        resume;

  logic [63:0] pc64, link64, faddr64;
  logic        valid64, fault64, halted64;
  logic [7:0]  pc8, link8, faddr8;
  logic        valid8, fault8, halted8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut64 (
    .CLOCK         (clk),
    .RESET         (reset),
    .PC_READY      (pc_ready),
    .STALL         (stall),
    .BRANCH_TAKEN  (branch_taken),
    .BRANCH_TARGET (branch_target),
    .HALT_REQ      (halt_req),
    .RESUME        (resume),
    .PC            (pc64),
    .PC_VALID      (valid64),
    .PC_LINK       (link64),
    .ALIGN_FAULT   (fault64),
    .FAULT_ADDR    (faddr64),
    .HALTED        (halted64)
  );

  pc_sequencer #(.WIDTH(8)) dut8 (
    .CLOCK         (clk),
    .RESET         (reset),
    .PC_READY      (pc_ready),
    .STALL         (stall),
    .BRANCH_TAKEN  (branch_taken),
    .BRANCH_TARGET (branch_target[7:0]),
    .HALT_REQ      (halt_req),
    .RESUME        (resume),
    .PC            (pc8),
    .PC_VALID      (valid8),
    .PC_LINK       (link8),
    .ALIGN_FAULT   (fault8),
    .FAULT_ADDR    (faddr8),
    .HALTED        (halted8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt_req = 1'b0; resume = 1'b0;
    step(); step();
    checks++; if (pc64 !== 64'h0) begin errors++; $display("FAIL reset_pc actual=%0h required=0", pc64); end
    checks++; if (valid64 !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%0b required=0", valid64); end
    checks++; if (fault64 !== 1'b0 || faddr64 !== 64'h0) begin errors++; $display("FAIL reset_fault actual=%0b/%0h required=0/0", fault64, faddr64); end
    checks++; if (halted64 !== 1'b0) begin errors++; $display("FAIL reset_halted actual=%0b required=0", halted64); end
    // Boot hold: first low edge keeps valid low, second raises it.
    reset = 1'b0;
    step();
    checks++; if (valid64 !== 1'b0) begin errors++; $display("FAIL boot_valid_1 actual=%0b required=0", valid64); end
    step();
    checks++; if (valid64 !== 1'b1 || pc64 !== 64'h0) begin errors++; $display("FAIL boot_valid_2 actual=%0b/%0h required=1/0", valid64, pc64); end
  endtask

  task automatic test_sequential();
    step();
    checks++; if (pc64 !== 64'h4) begin errors++; $display("FAIL seq_4 actual=%0h required=4", pc64); end
    step();
    checks++; if (pc64 !== 64'h8) begin errors++; $display("FAIL seq_8 actual=%0h required=8", pc64); end
  endtask

  task automatic test_hold();
    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc64 !== 64'h8 || valid64 !== 1'b1) begin errors++; $display("FAIL ready_hold_%0d actual=%0h/%0b required=8/1", i, pc64, valid64); end
    end
    pc_ready = 1'b1;
    step();
    checks++; if (pc64 !== 64'hC) begin errors++; $display("FAIL ready_release actual=%0h required=c", pc64); end
    stall = 1'b1;
    step(); step();
    checks++; if (pc64 !== 64'hC || valid64 !== 1'b1) begin errors++; $display("FAIL stall_hold actual=%0h/%0b required=c/1", pc64, valid64); end
    stall = 1'b0;
    step();
    checks++; if (pc64 !== 64'h10) begin errors++; $display("FAIL stall_release actual=%0h required=10", pc64); end
    checks++; if (link64 !== 64'h14) begin errors++; $display("FAIL link actual=%0h required=14", link64); end
  endtask

  task automatic test_branch();
    pc_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h40;
    step();
    checks++; if (pc64 !== 64'h40 || fault64 !== 1'b0) begin errors++; $display("FAIL branch_not_ready actual=%0h/%0b required=40/0", pc64, fault64); end
    pc_ready = 1'b1; branch_target = 64'h80;
    step();
    checks++; if (pc64 !== 64'h80) begin errors++; $display("FAIL branch_over_accept actual=%0h required=80", pc64); end
    branch_taken = 1'b0;
  endtask

  task automatic test_fault();
    pc_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h42;
    step();
    checks++; if (pc64 !== 64'h100) begin errors++; $display("FAIL fault_pc actual=%0h required=100", pc64); end
    checks++; if (faddr64 !== 64'h42 || fault64 !== 1'b1) begin errors++; $display("FAIL fault_capture actual=%0h/%0b required=42/1", faddr64, fault64); end
    branch_taken = 1'b0;
    step();
    checks++; if (fault64 !== 1'b0 || pc64 !== 64'h100 || faddr64 !== 64'h42) begin errors++; $display("FAIL fault_pulse actual=%0b/%0h/%0h required=0/100/42", fault64, pc64, faddr64); end
  endtask

  task automatic test_halt();
    branch_taken = 1'b1; branch_target = 64'h10;
    step();
    branch_taken = 1'b0; halt_req = 1'b1;
    step();
    checks++; if (halted64 !== 1'b1 || valid64 !== 1'b0 || pc64 !== 64'h10) begin errors++; $display("FAIL halt_enter actual=%0b/%0b/%0h required=1/0/10", halted64, valid64, pc64); end
    halt_req = 1'b0; pc_ready = 1'b1;
    step();
    checks++; if (halted64 !== 1'b1 || pc64 !== 64'h10) begin errors++; $display("FAIL halt_hold actual=%0b/%0h required=1/10", halted64, pc64); end
    branch_taken = 1'b1; branch_target = 64'h80;
    step();
    checks++; if (pc64 !== 64'h80 || halted64 !== 1'b1) begin errors++; $display("FAIL halt_branch actual=%0h/%0b required=80/1", pc64, halted64); end
    branch_taken = 1'b0; halt_req = 1'b1; resume = 1'b1;
    step();
    checks++; if (halted64 !== 1'b1 || valid64 !== 1'b0) begin errors++; $display("FAIL halt_both actual=%0b/%0b required=1/0", halted64, valid64); end
    halt_req = 1'b0;
    step();
    checks++; if (valid64 !== 1'b1 || halted64 !== 1'b0 || pc64 !== 64'h80) begin errors++; $display("FAIL resume actual=%0b/%0b/%0h required=1/0/80", valid64, halted64, pc64); end
    // Accept in the same cycle as the halt request still advances the PC.
    resume = 1'b0; halt_req = 1'b1;
    step();
    checks++; if (pc64 !== 64'h84 || halted64 !== 1'b1) begin errors++; $display("FAIL halt_with_accept actual=%0h/%0b required=84/1", pc64, halted64); end
    halt_req = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    checks++; if (valid64 !== 1'b1 || pc64 !== 64'h84) begin errors++; $display("FAIL resume_2 actual=%0b/%0h required=1/84", valid64, pc64); end
  endtask

  task automatic test_wrap();
    pc_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'hFC;
    step();
    branch_taken = 1'b0;
    checks++; if (pc8 !== 8'hFC || link8 !== 8'h00) begin errors++; $display("FAIL wrap_link8 actual=%0h/%0h required=fc/0", pc8, link8); end
    checks++; if (link64 !== 64'h100) begin errors++; $display("FAIL link64 actual=%0h required=100", link64); end
    pc_ready = 1'b1;
    step();
    checks++; if (pc8 !== 8'h00 || valid8 !== 1'b1) begin errors++; $display("FAIL wrap_pc8 actual=%0h/%0b required=0/1", pc8, valid8); end
    checks++; if (pc64 !== 64'h100) begin errors++; $display("FAIL nowrap_pc64 actual=%0h required=100", pc64); end
  endtask

  task automatic test_reset_override();
    pc_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'hFC;
    step();
    checks++; if (pc8 !== 8'hFC) begin errors++; $display("FAIL pre_reset_pc8 actual=%0h required=fc", pc8); end
    // Reset with a misaligned branch and an accept pending on the same edge.
    pc_ready = 1'b1; reset = 1'b1; branch_target = 64'h42;
    step();
    checks++; if (pc8 !== 8'h00 || pc64 !== 64'h0) begin errors++; $display("FAIL reset_override_pc actual=%0h/%0h required=0/0", pc8, pc64); end
    checks++; if (fault64 !== 1'b0 || faddr64 !== 64'h0 || valid64 !== 1'b0) begin errors++; $display("FAIL reset_override_fault actual=%0b/%0h/%0b required=0/0/0", fault64, faddr64, valid64); end
    // A branch during boot is ignored.
    reset = 1'b0; branch_target = 64'h40;
    step();
    checks++; if (pc64 !== 64'h0 || valid64 !== 1'b0) begin errors++; $display("FAIL boot_branch_ignored actual=%0h/%0b required=0/0", pc64, valid64); end
    branch_taken = 1'b0;
    step();
    checks++; if (pc64 !== 64'h0 || valid64 !== 1'b1) begin errors++; $display("FAIL reboot actual=%0h/%0b required=0/1", pc64, valid64); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_branch();
    test_fault();
    test_halt();
    test_wrap();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
